// File: rtl/vector_serializer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vector_serializer_if : vector load channel plus element stream channel
// Revision: 1.0
// ============================================================================
interface vector_serializer_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [IDX_W-1:0]     out_index;
  logic                 out_last;

  // master: the surrounding logic that supplies vectors and consumes elements
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  // slave: the serializer itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

`default_nettype wire

// File: rtl/vector_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vector_serializer : captures an N-element vector in one handshake and
//                     streams it out one element per cycle, no inter-vector bubble
// Revision: 1.0
// ============================================================================
module vector_serializer #(
  parameter int WIDTH = 16,
  parameter int N     = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  vector_serializer_if.slave bus
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0]       c_IDLE     = 1'b0;
  localparam logic [0:0]       c_SEND     = 1'b1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N - 1);

  logic [0:0]         r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [N*WIDTH-1:0] r_buf;

  logic w_at_last;
  logic w_out_fire;
  logic w_load;

  assign w_at_last  = (r_idx == c_LAST_IDX);
  assign w_out_fire = bus.out_valid & bus.out_ready;

  assign bus.out_valid = (r_state == c_SEND);
  assign bus.out_last  = bus.out_valid & w_at_last;
  assign bus.out_index = r_idx;
  assign bus.out_data  = r_buf[int'(r_idx) * WIDTH +: WIDTH];

  // Accepting while the last element leaves is what removes the bubble between vectors
  assign bus.in_ready = (r_state == c_IDLE) | (w_out_fire & w_at_last);
  assign w_load       = bus.in_valid & bus.in_ready;

  // rst is active-low and asynchronous
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
      r_idx   <= '0;
      r_buf   <= '0;
    end else if (w_load) begin
      r_buf   <= bus.in_data;
      r_idx   <= '0;
      r_state <= c_SEND;
    end else if (w_out_fire) begin
      if (w_at_last) begin
        r_idx   <= '0;
        r_state <= c_IDLE;
      end else begin
        r_idx   <= r_idx + IDX_W'(1);
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_vector_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_vector_serializer : directed vectors, queue scoreboard popped by a monitor
// Revision: 1.0
// ============================================================================
module tb_vector_serializer;
  localparam int WIDTH = 5;
  localparam int N     = 4;
  localparam int IDX_W = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [IDX_W-1:0] idx;
    logic             last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vector_serializer_if #(.WIDTH(WIDTH), .N(N)) bus();

  vector_serializer #(.WIDTH(WIDTH), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t exp_q[$];
  beat_t mon_e;
  int checks   = 0;
  int failures = 0;

  localparam logic [N*WIDTH-1:0] c_VEC_A = {5'h04, 5'h03, 5'h02, 5'h01};
  localparam logic [N*WIDTH-1:0] c_VEC_B = {5'h1F, 5'h0A, 5'h15, 5'h10};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Push the expected beats of a vector, first 'count' elements only
  task automatic push_vec(input logic [N*WIDTH-1:0] v, input int count);
    logic [N*WIDTH-1:0] tmp;
    tmp = v;
    for (int k = 0; k < count; k++) begin
      exp_q.push_back('{data: tmp[k*WIDTH +: WIDTH], idx: IDX_W'(k), last: (k == N-1)});
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.out_valid), 32'd0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got data %0h idx %0d, no beat expected at %0t",
                 bus.out_data, bus.out_index, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_data",  32'(bus.out_data),  32'(mon_e.data));
        check("beat_index", 32'(bus.out_index), 32'(mon_e.idx));
        check("beat_last",  32'(bus.out_last),  32'(mon_e.last));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset held for 3.25 cycles
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_index", 32'(bus.out_index), 32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    end
    #2.5 rst = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("post_rst_out_data",  32'(bus.out_data),  32'd0);

    // Single vector, full throughput
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.in_data   = c_VEC_A;
    bus.in_valid  = 1'b1;
    push_vec(c_VEC_A, N);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check("single_out_valid", 32'(bus.out_valid), 32'd1);
      check("single_in_ready",  32'(bus.in_ready),  32'(k == N-1));
    end
    wait_idle("single_idle");

    // Backpressure on element 2
    @(posedge clk); #1;
    bus.in_data  = c_VEC_A;
    bus.in_valid = 1'b1;
    push_vec(c_VEC_A, N);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_data",  32'(bus.out_data),  32'h03);
      check("bp_out_index", 32'(bus.out_index), 32'd2);
      check("bp_out_last",  32'(bus.out_last),  32'd0);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_idle("bp_idle");

    // Back-to-back vectors, second offered during the first one's last beat
    @(posedge clk); #1;
    bus.in_data  = c_VEC_A;
    bus.in_valid = 1'b1;
    push_vec(c_VEC_A, N);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("b2b_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk); #1;
    bus.in_data  = c_VEC_B;
    bus.in_valid = 1'b1;
    push_vec(c_VEC_B, N);
    @(negedge clk);
    check("b2b_out_valid",     32'(bus.out_valid), 32'd1);
    check("b2b_in_ready_last", 32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (N) begin
      @(negedge clk);
      check("b2b_out_valid", 32'(bus.out_valid), 32'd1);
    end
    wait_idle("b2b_idle");

    // Busy input ignored: in_valid held with changing in_data during beats 0-2
    @(posedge clk); #1;
    bus.in_data  = c_VEC_A;
    bus.in_valid = 1'b1;
    push_vec(c_VEC_A, N);
    @(posedge clk); #1;
    bus.in_data = {5'h11, 5'h12, 5'h13, 5'h14};
    @(posedge clk); #1;
    bus.in_data = {5'h1E, 5'h1D, 5'h1C, 5'h1B};
    @(posedge clk); #1;
    bus.in_data = c_VEC_B;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_idle("busy_idle");

    // Reset mid-vector: only beats 0 and 1 complete
    @(posedge clk); #1;
    bus.in_data  = c_VEC_A;
    bus.in_valid = 1'b1;
    push_vec(c_VEC_A, 2);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    check("midrst_out_index", 32'(bus.out_index), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    bus.in_data  = c_VEC_B;
    bus.in_valid = 1'b1;
    push_vec(c_VEC_B, N);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("after_rst_first_data",  32'(bus.out_data),  32'h10);
    check("after_rst_first_index", 32'(bus.out_index), 32'd0);
    wait_idle("after_rst_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
